// File: rtl/hp_controller.sv
// Player HP state, damage/heal arbitration, post-hit invulnerability timing,
// and a frame-stable HP bar width computed by a sequential restoring divider.
module hp_controller #(
    parameter int HP_MAX        = 20,
    parameter int BAR_W         = 100,
    parameter int INVULN_FRAMES = 60,
    parameter int BLINK_FRAMES  = 4
) (
    input  logic       Pclk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       damage_req,
    input  logic [7:0] damage_amt,
    input  logic       heal_req,
    input  logic [7:0] heal_amt,
    input  logic       restart,
    output logic [7:0] hp,
    output logic [9:0] bar_fill,
    output logic       invuln,
    output logic       blink,
    output logic       dead,
    output logic       hit_ack
);

    // state   | meaning
    // ALIVE   | accepts damage and heal
    // INVULN  | post-hit grace period; damage ignored, frames counted
    // DEAD    | hp is 0; only restart leaves
    typedef enum logic [1:0] {S_ALIVE, S_INVULN, S_DEAD} state_t;

    localparam logic [7:0] HP_FULL      = 8'(HP_MAX);
    localparam logic [7:0] INV_LAST     = 8'(INVULN_FRAMES);
    localparam logic [7:0] BLINK_RELOAD = 8'(BLINK_FRAMES - 1);
    localparam logic [9:0] BAR_FULL     = 10'(BAR_W);
    localparam logic [3:0] DIV_START    = 4'd12;

    state_t     state;
    logic [7:0] frame_cnt;
    logic [7:0] blink_cnt;

    logic [7:0] hp_dmg;
    logic [8:0] heal_sum;
    logic [7:0] heal_hp;
    logic [8:0] dmg_heal_sum;
    logic [7:0] dmg_heal_hp;
    logic [7:0] frame_next;

    always_comb begin
        hp_dmg       = (hp > damage_amt) ? (hp - damage_amt) : 8'd0;
        heal_sum     = {1'b0, hp} + {1'b0, heal_amt};
        heal_hp      = (heal_sum > {1'b0, HP_FULL}) ? HP_FULL : heal_sum[7:0];
        dmg_heal_sum = {1'b0, hp_dmg} + {1'b0, (heal_req ? heal_amt : 8'd0)};
        dmg_heal_hp  = (dmg_heal_sum > {1'b0, HP_FULL}) ? HP_FULL : dmg_heal_sum[7:0];
        frame_next   = frame_cnt + 8'd1;
    end

    always_ff @(posedge Pclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_ALIVE;
            hp        <= HP_FULL;
            frame_cnt <= 8'd0;
            blink_cnt <= 8'd0;
            invuln    <= 1'b0;
            blink     <= 1'b0;
            dead      <= 1'b0;
            hit_ack   <= 1'b0;
        end else begin
            hit_ack <= 1'b0;
            if (restart) begin
                state     <= S_ALIVE;
                hp        <= HP_FULL;
                frame_cnt <= 8'd0;
                blink_cnt <= 8'd0;
                invuln    <= 1'b0;
                blink     <= 1'b0;
                dead      <= 1'b0;
            end else begin
                case (state)
                    S_ALIVE: begin
                        if (damage_req) begin
                            hit_ack <= 1'b1;
                            // a killing blow discards any same-cycle heal
                            if (hp_dmg == 8'd0) begin
                                hp    <= 8'd0;
                                state <= S_DEAD;
                                dead  <= 1'b1;
                            end else begin
                                hp        <= dmg_heal_hp;
                                state     <= S_INVULN;
                                invuln    <= 1'b1;
                                blink     <= 1'b0;
                                frame_cnt <= 8'd0;
                                blink_cnt <= BLINK_RELOAD;
                            end
                        end else if (heal_req) begin
                            hp <= heal_hp;
                        end
                    end
                    S_INVULN: begin
                        if (heal_req) hp <= heal_hp;
                        if (frame_tick) begin
                            if (frame_next == INV_LAST) begin
                                state     <= S_ALIVE;
                                invuln    <= 1'b0;
                                blink     <= 1'b0;
                                frame_cnt <= 8'd0;
                            end else begin
                                frame_cnt <= frame_next;
                                if (blink_cnt == 8'd0) begin
                                    blink     <= ~blink;
                                    blink_cnt <= BLINK_RELOAD;
                                end else begin
                                    blink_cnt <= blink_cnt - 8'd1;
                                end
                            end
                        end
                    end
                    S_DEAD: ;
                    default: state <= S_ALIVE;
                endcase
            end
        end
    end

    // Divider: cnt 12 forms the product, 11..2 produce one quotient bit each,
    // 1 publishes. Product >> 10 is always below HP_MAX, so 10 bits suffice.
    logic [3:0]  div_cnt;
    logic [7:0]  hp_snap;
    logic [7:0]  div_rem;
    logic [9:0]  div_q;
    logic [17:0] product;
    logic [8:0]  trial;
    logic        trial_ge;
    logic [7:0]  trial_sub;

    always_comb begin
        product   = {10'd0, hp_snap} * {8'd0, BAR_FULL};
        trial     = {div_rem, div_q[9]};
        trial_ge  = (trial >= {1'b0, HP_FULL});
        trial_sub = trial[7:0] - HP_FULL;
    end

    always_ff @(posedge Pclk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= 4'd0;
            hp_snap  <= 8'd0;
            div_rem  <= 8'd0;
            div_q    <= 10'd0;
            bar_fill <= BAR_FULL;
        end else if (div_cnt == 4'd0) begin
            if (frame_tick) begin
                hp_snap <= hp;
                div_cnt <= DIV_START;
            end
        end else begin
            div_cnt <= div_cnt - 4'd1;
            if (div_cnt == DIV_START) begin
                div_rem <= product[17:10];
                div_q   <= product[9:0];
            end else if (div_cnt >= 4'd2) begin
                div_rem <= trial_ge ? trial_sub : trial[7:0];
                div_q   <= {div_q[8:0], trial_ge};
            end else begin
                bar_fill <= div_q;
            end
        end
    end

endmodule
